// File: rtl/crypto_instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_instr_pkg
// Description : Shared constants for the crypto scalar functional unit and
//               the result queue that sits directly behind it.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_instr_pkg;

    // Default number of result queue entries (power of two, >= 2).
    localparam int CryptoResultQueueDepth = 4;

endpackage : crypto_instr_pkg
`default_nettype wire

// File: rtl/crypto_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : crypto_credit_ctr
// Description : Issue credit tracking for the crypto result queue. A slot is
//               reserved for every accepted issue during the one cycle the FU
//               takes to produce its result ("pending"), so the FU is only
//               started when its result is guaranteed a place in the queue.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_issue_fire       - instruction dispatched this cycle
//               i_count            - current queue occupancy
//               o_issue_ready      - a slot is guaranteed for a new issue
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_credit_ctr #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_issue_fire,
    input  logic [CW-1:0] i_count,
    output logic          o_issue_ready
);

    logic          r_pending;
    logic [CW:0]   w_used;

    // One extra bit so count + pending cannot wrap before the compare.
    assign w_used        = {1'b0, i_count} + {{CW{1'b0}}, r_pending};
    assign o_issue_ready = (w_used < (CW + 1)'(DEPTH));

    // Fires issued while not ready carry no credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= i_issue_fire && o_issue_ready;
        end
    end

endmodule : crypto_credit_ctr
`default_nettype wire

// File: rtl/crypto_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : crypto_result_queue
// Description : Result FIFO behind the crypto scalar FU. Captures every FU
//               result (no backpressure on the FU side), presents the head to
//               writeback with valid/ready, and drives issue credits.
//               Optional macro CRYPTO_RESULT_QUEUE_BYPASS_EN: when the queue
//               is empty an FU result drives the outputs in the same cycle
//               and, if accepted, is never written to storage.
// Ports       : clk_i, rst_i                  - clock, sync active-high reset
//               issue_fire_i / issue_ready_o  - issue credit handshake
//               fu_*_i                        - FU result capture
//               result_valid_o/result_ready_i - head handshake
//               result_o..we_o                - head entry (0 when not valid)
//               overflow_o                    - sticky dropped-result flag
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_result_queue
    import crypto_instr_pkg::*;
#(
    parameter int  XLEN     = 64,
    parameter int  Depth    = CryptoResultQueueDepth,
    parameter type hartid_t = logic,
    parameter type id_t     = logic
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_fire_i,
    output logic            issue_ready_o,
    input  logic            fu_valid_i,
    input  logic [XLEN-1:0] fu_result_i,
    input  hartid_t         fu_hartid_i,
    input  id_t             fu_id_i,
    input  logic [4:0]      fu_rd_i,
    input  logic            fu_we_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output hartid_t         hartid_o,
    output id_t             id_o,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic            overflow_o
);

    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    typedef struct packed {
        logic [XLEN-1:0] result;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t          r_mem [Depth];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    entry_t          w_fu_entry;
    entry_t          w_head;
    entry_t          w_out;
    logic            w_empty;
    logic            w_full;
    logic            w_bypass;
    logic            w_valid;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_drop;

    assign w_fu_entry = '{result: fu_result_i, hartid: fu_hartid_i,
                          id: fu_id_i, rd: fu_rd_i, we: fu_we_i};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(Depth));

`ifdef CRYPTO_RESULT_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && fu_valid_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = !w_empty || w_bypass;

    // A handshake on a bypassed entry does not touch storage.
    assign w_pop      = w_valid && result_ready_i && !w_empty;
    assign w_push_req = fu_valid_i && !(w_bypass && result_ready_i);
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_head = w_bypass ? w_fu_entry : r_mem[r_rptr];
    assign w_out  = w_valid ? w_head : '0;

    assign result_valid_o = w_valid;
    assign result_o       = w_out.result;
    assign hartid_o       = w_out.hartid;
    assign id_o           = w_out.id;
    assign rd_o           = w_out.rd;
    assign we_o           = w_out.we;
    assign overflow_o     = r_overflow;

    // Storage is not reset; only pointers/count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_fu_entry;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    crypto_credit_ctr #(
        .DEPTH (Depth),
        .CW    (CW)
    ) u_credit (
        .clk           (clk_i),
        .rst           (rst_i),
        .i_issue_fire  (issue_fire_i),
        .i_count       (r_count),
        .o_issue_ready (issue_ready_o)
    );

endmodule : crypto_result_queue
`default_nettype wire

// File: doc/crypto_result_queue.md
# crypto_result_queue

Result buffer directly downstream of the crypto scalar functional unit. The FU emits one registered result per cycle with no backpressure. This block captures every FU result (result, hartid, id, rd, we) into a small FIFO and presents it to the writeback/result interface with a valid/ready handshake. It also issues credit-based `issue_ready_o` back to the issue stage, so the FU is never started when its result could not be stored.

## Interface
Parameters:
- XLEN, 64, result width
- Depth, 4, FIFO entries; power of two, ≥2
- hartid_t, logic, hart identifier type
- id_t, logic, instruction identifier type

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- issue_fire_i  in  1  instruction dispatched to the FU this cycle
- issue_ready_o  out  1  a queue slot is guaranteed for a new issue
- fu_valid_i  in  1  FU result valid (FU `valid_o`)
- fu_result_i  in  XLEN  FU result
- fu_hartid_i  in  hartid_t  FU hart id
- fu_id_i  in  id_t  FU instruction id
- fu_rd_i  in  5  destination register
- fu_we_i  in  1  register write enable
- result_valid_o  out  1  head entry valid
- result_ready_i  in  1  consumer accepts head
- result_o  out  XLEN  head result
- hartid_o  out  hartid_t  head hart id
- id_o  out  id_t  head id
- rd_o  out  5  head rd
- we_o  out  1  head we
- overflow_o  out  1  sticky: a result was dropped

## Operation
- **Storage:** circular buffer of Depth entries.
  - Read and write pointers are $clog2(Depth) bits and wrap modulo Depth.
  - `count` is $clog2(Depth+1) bits.
- **Push:** when `fu_valid_i` is 1 and the entry is not bypassed, write it at the write pointer.
- **Pop:** occurs when `result_valid_o && result_ready_i`.
- **Credits:**
  - `pending` is a 1-bit register, set to `issue_fire_i && issue_ready_o`. This models the FU's 1-cycle latency.
  - `issue_ready_o = (count + pending) < Depth`, purely combinational from registers.
  - `issue_fire_i` while `issue_ready_o` is 0 is ignored for credit purposes.
- **Full with push and pop in the same cycle:** both happen; count is unchanged.
- **Full with push and no pop:** the entry is dropped and `overflow_o` is set. `overflow_o` stays 1 until reset. This case is a protocol violation and is unreachable if the credit rule is obeyed.
- **Push into an empty queue with no bypass:** visible at the outputs on the next cycle.
- **Output data:** `result_o`, `hartid_o`, `id_o`, `rd_o` and `we_o` are forced to 0 whenever `result_valid_o` is 0.
- **Handshake:** once `result_valid_o` is 1, the head and its data stay stable until popped.
- **Reset (`rst_i` = 1 at a clock edge):**
  - Pointers, count, `pending` and `overflow_o` clear to 0.
  - In-flight entries are discarded; memory contents are don't-care.
  - Reset takes priority over a simultaneous push or pop.

## Timing
- **Reset values:**
  - `result_valid_o` = 0, `issue_ready_o` = 1, `overflow_o` = 0.
  - All data outputs = 0.
- **Latency without bypass:** FU valid at cycle N → `result_valid_o` at cycle N+1.
- **Issue-to-result:** issue at cycle N → FU result at N+1 → queue output at N+2.
- **Throughput:** one push and one pop per cycle, sustained.
- **Credit recovery:** `issue_ready_o` reasserts the cycle after the pop that frees a slot.
- **Combinational paths:** only `result_ready_i` → pop logic. With bypass, `fu_*` inputs → outputs also become combinational.

## Configuration
- **Macro:** `CRYPTO_RESULT_QUEUE_BYPASS_EN`.
- **Defined:**
  - If `count == 0` and `fu_valid_i` is 1, the FU entry drives the outputs combinationally in the same cycle.
  - If `result_ready_i` is also 1, the entry is consumed and never written.
  - Otherwise it is pushed as normal.
- **Undefined:** there is no bypass; output always comes from storage, with 1-cycle latency.

## Structure
- **Shared package `crypto_instr_pkg`:** holds the constant `CryptoResultQueueDepth` (= 4), used as the Depth default at instantiation.
- **Entry bundle:** a local packed struct inside the module, since hartid_t and id_t are parameter types.
- **Sub-module `crypto_credit_ctr`:** holds the `pending`/count credit arithmetic and produces `issue_ready_o`.
- **Storage and pointers:** inline in the module.

## Test plan
- **Reset:** hold `rst_i` for 2 cycles with `fu_valid_i` = 1 → `result_valid_o` = 0, `issue_ready_o` = 1, `overflow_o` = 0, `result_o` = 0.
- **Single result, no bypass:** `fu_valid_i` for 1 cycle with `result` = 0xDEADBEEF_00000001, `rd` = 5, `id` = 3 → next cycle `result_valid_o` = 1 with those values. Holding `result_ready_i` = 0 for 3 cycles → outputs stay stable.
- **Fill with Depth = 4:** issue 4 back-to-back with `result_ready_i` = 0.
  - `issue_ready_o` drops to 0 after the 4th issue is accounted.
  - Then pop 4 in a row → results emerge in order 1, 2, 3, 4.
  - Pointers wrap, and `issue_ready_o` returns to 1.
- **Full with simultaneous push and pop:** → count stays 4, no overflow, order preserved.
- **Forced overflow:** drive a 5th `fu_valid_i` while full with no pop → `overflow_o` = 1, stays set. Stored entries are unchanged.
- **Bypass (with macro):** empty queue, `fu_valid_i` and `result_ready_i` both 1 → `result_valid_o` = 1 in the same cycle; count stays 0. Reset asserted mid-drain → empty the next cycle.
